pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum consecutive data-memory wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 SHALL have ports clk in 1 (single clock, rising edge) and rst in 1 (asynchronous, active-high reset).
REQ-004 SHALL have ports ID_rs1, ID_rs2 in 4 (decode-stage source registers) and ID_uses_rs1, ID_uses_rs2 in 1 (source valid).
REQ-005 SHALL have ports EX_MemRead in 1 (load in EX) and EX_rd in 4 (EX destination register).
REQ-006 SHALL have ports ID_is_branch in 1, ID_branch_taken in 1 (resolved in ID) and EX_sets_flags in 1 (EX writes flags).
REQ-007 SHALL have ports ID_halt in 1 (HLT in decode) and WB_halt in 1 (HLT in writeback).
REQ-008 SHALL have ports MEM_access in 1 (load/store in MEM) and DMEM_ready in 1 (memory completes this cycle).
REQ-009 SHALL have outputs PC_stall, IF_ID_stall, IF_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall and MEM_WB_flush, each 1 bit.
REQ-010 SHALL have outputs halted 1, mem_timeout 1 (sticky error) and stall_count CNT_W (saturating count of stalled cycles).

Function
REQ-011 SHALL implement states RUN, MEM_WAIT, HALTING and HALTED; the state is registered and the control outputs are combinational from the state and the current inputs.
REQ-012 SHALL define freeze = MEM_access & !DMEM_ready in RUN/MEM_WAIT/HALTING; freeze asserts PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall and MEM_WB_flush, and deasserts every other flush.
REQ-013 SHALL transition RUN->MEM_WAIT on freeze, and MEM_WAIT->RUN (or ->HALTING if a halt is pending) in the cycle DMEM_ready=1, with no freeze in that cycle.
REQ-014 SHALL define load_use = EX_MemRead & ((ID_uses_rs1 & ID_rs1==EX_rd) | (ID_uses_rs2 & ID_rs2==EX_rd)); R0 matches are treated as hazards.
REQ-015 SHALL define flag_use = ID_is_branch & EX_sets_flags.
REQ-016 SHALL, without freeze, on load_use|flag_use assert PC_stall, IF_ID_stall and ID_EX_flush for exactly that cycle; the branch is re-evaluated next cycle.
REQ-017 SHALL, without freeze or hazard, assert IF_flush for one cycle when ID_branch_taken=1.
REQ-018 SHALL apply priority freeze > hazard > branch flush; a flush is never asserted together with a stall of the same register.
REQ-019 SHALL, on ID_halt with no freeze or hazard in RUN, enter HALTING; in HALTING it asserts PC_stall=1 and IF_flush=1 every non-freeze cycle.
REQ-020 SHALL latch a halt-pending flag when ID_halt arrives during MEM_WAIT, and clear it on entry to HALTING.
REQ-021 SHALL move from HALTING to HALTED when WB_halt=1.
REQ-022 SHALL, in HALTED, assert halted=1, PC_stall=1 and IF_ID_stall=1 and ignore all other inputs; only rst exits HALTED.
REQ-023 SHALL count consecutive freeze cycles in a wait counter; when the counter reaches MEM_TIMEOUT, mem_timeout sets and stays set until rst, while the freeze continues.
REQ-024 SHALL clear the wait counter on any non-freeze cycle.
REQ-025 SHALL increment stall_count on each cycle with PC_stall=1 outside HALTED, saturating at all-ones.

Reset
REQ-026 SHALL, on rst, asynchronously set state=RUN, halt-pending=0, wait counter=0, stall_count=0, mem_timeout=0 and halted=0.
REQ-027 SHALL hold all stall/flush outputs at 0 during reset, regardless of the other inputs.
REQ-028 SHALL, on rst asserted mid-MEM_WAIT or mid-HALTING, abandon the operation with no residual stall on the first cycle after release.

Structure
REQ-029 SHALL take the state enum (hz_state_t) and the default MEM_TIMEOUT from the shared package cpu_ctrl_pkg.
REQ-030 SHALL contain one sub-module, hazard_detect (combinational load_use/flag_use), with the FSM and counters in the top level.

Verification
REQ-031 SHALL test load-use: EX_MemRead=1, EX_rd=3, ID_rs1=3, ID_uses_rs1=1 -> one cycle of PC_stall=IF_ID_stall=ID_EX_flush=1, stall_count=1.
REQ-032 SHALL test branch taken with no hazard -> IF_flush=1 for one cycle; taken branch plus flag_use -> stall first, then IF_flush next cycle.
REQ-033 SHALL test MEM_access=1 with DMEM_ready low for 4 cycles -> all freeze outputs high for 4 cycles, state MEM_WAIT, release on the ready cycle, no flushes.
REQ-034 SHALL test DMEM_ready low for 20 cycles with MEM_TIMEOUT=15 -> mem_timeout rises on the 15th freeze cycle and stays high after ready.
REQ-035 SHALL test ID_halt, then WB_halt 3 cycles later -> HALTING with PC_stall=1 and IF_flush=1, then halted=1 permanently until rst.
REQ-036 SHALL test rst pulsed during MEM_WAIT with stall_count=7 -> all outputs 0 immediately, stall_count=0, state RUN.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: hazard-controller state encoding and default
// data-memory timeout.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTING  = 2'd2,
    HALTED   = 2'd3
  } hz_state_t;

  localparam int MEM_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Combinational detection of decode-stage hazards against the instruction in EX:
// load-use on a register source and branch-on-flags-being-written.
module hazard_detect (
  input  logic [3:0] ID_rs1,
  input  logic [3:0] ID_rs2,
  input  logic       ID_uses_rs1,
  input  logic       ID_uses_rs2,
  input  logic       EX_MemRead,
  input  logic [3:0] EX_rd,
  input  logic       ID_is_branch,
  input  logic       EX_sets_flags,
  output logic       load_use,
  output logic       flag_use
);

  // R0 is deliberately not excluded: a match on R0 still stalls.
  assign load_use = EX_MemRead &
                    ((ID_uses_rs1 & (ID_rs1 == EX_rd)) |
                     (ID_uses_rs2 & (ID_rs2 == EX_rd)));

  assign flag_use = ID_is_branch & EX_sets_flags;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: memory-wait freeze, load-use/flag stalls, branch
// flush and halt sequencing, with timeout and stall-cycle statistics.
module pipeline_hazard_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ID_rs1,
  input  logic [3:0]       ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             EX_MemRead,
  input  logic [3:0]       EX_rd,
  input  logic             ID_is_branch,
  input  logic             ID_branch_taken,
  input  logic             EX_sets_flags,
  input  logic             ID_halt,
  input  logic             WB_halt,
  input  logic             MEM_access,
  input  logic             DMEM_ready,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             IF_flush,
  output logic             ID_EX_stall,
  output logic             ID_EX_flush,
  output logic             EX_MEM_stall,
  output logic             MEM_WB_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t         state, state_nxt;
  logic              halt_pending, halt_pending_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use, flag_use, hazard, freeze;

  hazard_detect u_hazard_detect (
    .ID_rs1        (ID_rs1),
    .ID_rs2        (ID_rs2),
    .ID_uses_rs1   (ID_uses_rs1),
    .ID_uses_rs2   (ID_uses_rs2),
    .EX_MemRead    (EX_MemRead),
    .EX_rd         (EX_rd),
    .ID_is_branch  (ID_is_branch),
    .EX_sets_flags (EX_sets_flags),
    .load_use      (load_use),
    .flag_use      (flag_use)
  );

  assign hazard = load_use | flag_use;
  assign freeze = (state != HALTED) & MEM_access & ~DMEM_ready;
  assign halted = (state == HALTED);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt        = state;
    halt_pending_nxt = halt_pending;
    PC_stall         = 1'b0;
    IF_ID_stall      = 1'b0;
    IF_flush         = 1'b0;
    ID_EX_stall      = 1'b0;
    ID_EX_flush      = 1'b0;
    EX_MEM_stall     = 1'b0;
    MEM_WB_flush     = 1'b0;

    if (state == HALTED) begin
      PC_stall    = 1'b1;
      IF_ID_stall = 1'b1;
    end else if (freeze) begin
      PC_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_flush = 1'b1;
      if (state == RUN)      state_nxt        = MEM_WAIT;
      if (state == MEM_WAIT) halt_pending_nxt = halt_pending | ID_halt;
    end else if (state == HALTING) begin
      PC_stall = 1'b1;
      IF_flush = 1'b1;
    end else begin
      if (hazard) begin
        PC_stall    = 1'b1;
        IF_ID_stall = 1'b1;
        ID_EX_flush = 1'b1;
      end else begin
        IF_flush = ID_branch_taken;
      end
      if (halt_pending | (ID_halt & ~hazard)) begin
        state_nxt        = HALTING;
        halt_pending_nxt = 1'b0;
      end else begin
        state_nxt = RUN;
      end
    end

    // HLT retiring ends the drain even while the memory stage is frozen.
    if (state == HALTING && WB_halt) state_nxt = HALTED;

    if (rst) begin
      PC_stall     = 1'b0;
      IF_ID_stall  = 1'b0;
      IF_flush     = 1'b0;
      ID_EX_stall  = 1'b0;
      ID_EX_flush  = 1'b0;
      EX_MEM_stall = 1'b0;
      MEM_WB_flush = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      halt_pending <= 1'b0;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_count  <= '0;
    end else begin
      state        <= state_nxt;
      halt_pending <= halt_pending_nxt;

      if (freeze) begin
        if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (PC_stall && state != HALTED && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: single-cycle vector table,
// directed multi-cycle sequences and randomized traffic against a reference model.
module tb_pipeline_hazard_controller;

  localparam int T     = 15;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
  logic ID_uses_rs1 = 0, ID_uses_rs2 = 0, EX_MemRead = 0, ID_is_branch = 0;
  logic ID_branch_taken = 0, EX_sets_flags = 0, ID_halt = 0, WB_halt = 0;
  logic MEM_access = 0, DMEM_ready = 0;
  logic PC_stall, IF_ID_stall, IF_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush;
  logic halted, mem_timeout;
  logic [CNT_W-1:0] stall_count;

  pipeline_hazard_controller #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
    .ID_is_branch(ID_is_branch), .ID_branch_taken(ID_branch_taken), .EX_sets_flags(EX_sets_flags),
    .ID_halt(ID_halt), .WB_halt(WB_halt), .MEM_access(MEM_access), .DMEM_ready(DMEM_ready),
    .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .IF_flush(IF_flush),
    .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush), .EX_MEM_stall(EX_MEM_stall),
    .MEM_WB_flush(MEM_WB_flush), .halted(halted), .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] rs1, rs2;
    logic       u1, u2, mr;
    logic [3:0] exrd;
    logic       br, tk, sf, idh, wbh, ma, rdy;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [6:0] exp;
  } vec_t;

  // Output vector order: PC_stall, IF_ID_stall, IF_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush
  localparam logic [6:0] O_NONE   = 7'b0000000;
  localparam logic [6:0] O_FREEZE = 7'b1101011;
  localparam logic [6:0] O_HAZ    = 7'b1100100;
  localparam logic [6:0] O_BRF    = 7'b0010000;
  localparam logic [6:0] O_DRAIN  = 7'b1010000;
  localparam logic [6:0] O_HALTED = 7'b1100000;

  int errors = 0;
  int checks = 0;

  // Reference model: a pipeline that is either halted, draining toward a halt,
  // or running (possibly inside a memory wait that may carry a pending halt).
  bit m_halted, m_drain, m_wait, m_pend, m_to;
  int m_waitc, m_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs_now();
    return {PC_stall, IF_ID_stall, IF_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush};
  endfunction

  task automatic apply(input in_t v);
    ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_uses_rs1 = v.u1; ID_uses_rs2 = v.u2;
    EX_MemRead = v.mr; EX_rd = v.exrd; ID_is_branch = v.br; ID_branch_taken = v.tk;
    EX_sets_flags = v.sf; ID_halt = v.idh; WB_halt = v.wbh; MEM_access = v.ma; DMEM_ready = v.rdy;
  endtask

  function automatic bit is_frz(input in_t v);
    return !m_halted && v.ma && !v.rdy;
  endfunction

  function automatic bit is_haz(input in_t v);
    return (v.mr && ((v.u1 && v.rs1 == v.exrd) || (v.u2 && v.rs2 == v.exrd))) || (v.br && v.sf);
  endfunction

  function automatic logic [6:0] exp_outs(input in_t v);
    if (m_halted)        return O_HALTED;
    else if (is_frz(v))  return O_FREEZE;
    else if (m_drain)    return O_DRAIN;
    else if (is_haz(v))  return O_HAZ;
    else                 return v.tk ? O_BRF : O_NONE;
  endfunction

  task automatic model_reset();
    m_halted = 0; m_drain = 0; m_wait = 0; m_pend = 0; m_to = 0; m_waitc = 0; m_stall = 0;
  endtask

  task automatic model_step(input in_t v);
    bit frz, haz, pc;
    logic [6:0] o;
    frz = is_frz(v);
    haz = is_haz(v);
    o   = exp_outs(v);
    pc  = o[6];
    if (pc && !m_halted && m_stall < CMAX) m_stall++;
    m_waitc = frz ? ((m_waitc < T) ? m_waitc + 1 : T) : 0;
    if (m_waitc == T) m_to = 1;
    if (m_halted) begin
    end else if (m_drain) begin
      if (v.wbh) m_halted = 1;
    end else if (frz) begin
      if (m_wait) m_pend = m_pend | v.idh;
      m_wait = 1;
    end else begin
      if (m_pend || (v.idh && !haz)) m_drain = 1;
      m_wait = 0;
      m_pend = 0;
    end
  endtask

  function automatic in_t rand_in(input int rdy_low_pct);
    in_t v;
    v.rs1  = 4'($urandom_range(0, 3));
    v.rs2  = 4'($urandom_range(0, 3));
    v.exrd = 4'($urandom_range(0, 3));
    v.u1   = 1'($urandom_range(0, 1));
    v.u2   = 1'($urandom_range(0, 1));
    v.mr   = ($urandom_range(0, 99) < 30);
    v.br   = ($urandom_range(0, 99) < 30);
    v.tk   = v.br & 1'($urandom_range(0, 1));
    v.sf   = ($urandom_range(0, 99) < 30);
    v.idh  = ($urandom_range(0, 99) < 4);
    v.wbh  = ($urandom_range(0, 99) < 25);
    v.ma   = ($urandom_range(0, 99) < 40);
    v.rdy  = ($urandom_range(0, 99) >= rdy_low_pct);
    return v;
  endfunction

  // One clock: drive after the rising edge, compare on the falling edge, then
  // advance the model for the rising edge that follows.
  task automatic cycle(input string tag, input in_t v);
    @(posedge clk); #1;
    apply(v);
    @(negedge clk);
    check({tag, "_outs"},   32'(outs_now()),   32'(exp_outs(v)));
    check({tag, "_halted"}, 32'(halted),       32'(m_halted));
    check({tag, "_cnt"},    32'(stall_count),  32'(m_stall));
    check({tag, "_tmo"},    32'(mem_timeout),  32'(m_to));
    model_step(v);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    apply(rand_in(50));
    #1;
    check("rst_outs",   32'(outs_now()),  0);
    check("rst_cnt",    32'(stall_count), 0);
    check("rst_halted", 32'(halted),      0);
    check("rst_tmo",    32'(mem_timeout), 0);
    @(posedge clk);
    @(negedge clk);
    apply('0);
    rst = 1'b0;
    model_reset();
  endtask

  in_t  v, idle, lu, frz_in;
  vec_t tbl[11];

  initial begin
    idle = '0;
    lu = '0; lu.mr = 1; lu.exrd = 4'd3; lu.rs1 = 4'd3; lu.u1 = 1;
    frz_in = '0; frz_in.ma = 1;

    // Single-cycle vectors, each applied from a fresh reset.
    v = lu;                                                   tbl[0]  = '{"lu_rs1",     v, O_HAZ};
    v = '0; v.mr = 1; v.exrd = 4'd5; v.rs2 = 4'd5; v.u2 = 1; tbl[1]  = '{"lu_rs2",     v, O_HAZ};
    v = lu; v.u1 = 0;                                         tbl[2]  = '{"lu_unused",  v, O_NONE};
    v = '0; v.mr = 1; v.u1 = 1;                               tbl[3]  = '{"lu_r0",      v, O_HAZ};
    v = lu; v.mr = 0;                                         tbl[4]  = '{"no_load",    v, O_NONE};
    v = '0; v.br = 1; v.sf = 1;                               tbl[5]  = '{"flag_use",   v, O_HAZ};
    v = '0; v.br = 1; v.tk = 1; v.sf = 1;                     tbl[6]  = '{"flag_taken", v, O_HAZ};
    v = '0; v.br = 1; v.tk = 1;                               tbl[7]  = '{"br_taken",   v, O_BRF};
    v = frz_in;                                               tbl[8]  = '{"freeze",     v, O_FREEZE};
    v = frz_in; v.br = 1; v.tk = 1; v.sf = 1; v.mr = 1; v.u1 = 1; tbl[9] = '{"frz_prio", v, O_FREEZE};
    v = frz_in; v.rdy = 1;                                    tbl[10] = '{"mem_ready",  v, O_NONE};

    model_reset();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      do_reset();
      @(posedge clk); #1;
      apply(tbl[i].in);
      @(negedge clk);
      check(tbl[i].name, 32'(outs_now()), 32'(tbl[i].exp));
    end

    // Load-use: exactly one stall cycle, counted once.
    do_reset();
    cycle("lu", lu);
    check("lu_stall", 32'(outs_now()), 32'(O_HAZ));
    cycle("lu_next", idle);
    check("lu_release", 32'(outs_now()), 32'(O_NONE));
    check("lu_count", 32'(stall_count), 1);

    // Taken branch behind a flag writer: stall first, flush on re-evaluation.
    do_reset();
    v = '0; v.br = 1; v.tk = 1; v.sf = 1;
    cycle("bf1", v);
    check("bf_stall", 32'(outs_now()), 32'(O_HAZ));
    v.sf = 0;
    cycle("bf2", v);
    check("bf_flush", 32'(outs_now()), 32'(O_BRF));
    cycle("bf3", idle);

    // Four-cycle memory wait.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle("mw", frz_in);
      check("mw_frz", 32'(outs_now()), 32'(O_FREEZE));
    end
    v = frz_in; v.rdy = 1;
    cycle("mw_rdy", v);
    check("mw_release", 32'(outs_now()), 32'(O_NONE));
    cycle("mw_after", idle);
    check("mw_count", 32'(stall_count), 4);

    // Twenty-cycle wait: timeout rises after the 15th freeze cycle and sticks.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cycle("to", frz_in);
      check("to_rise", 32'(mem_timeout), (k > T) ? 1 : 0);
    end
    v = frz_in; v.rdy = 1;
    cycle("to_rdy", v);
    cycle("to_after", idle);
    check("to_sticky", 32'(mem_timeout), 1);

    // Halt in decode, retire three cycles later, then stuck halted.
    do_reset();
    v = '0; v.idh = 1;
    cycle("h0", v);
    cycle("h1", idle);
    check("h_drain", 32'(outs_now()), 32'(O_DRAIN));
    cycle("h2", idle);
    v = '0; v.wbh = 1;
    cycle("h3", v);
    for (int k = 0; k < 6; k++) begin
      cycle("hd", rand_in(50));
      check("h_halted", 32'(halted), 1);
      check("h_outs", 32'(outs_now()), 32'(O_HALTED));
    end
    do_reset();
    cycle("h_exit", idle);
    check("h_cleared", 32'(halted), 0);

    // Reset pulsed in the middle of a memory wait with seven stalls counted.
    do_reset();
    for (int k = 0; k < 8; k++) cycle("rw", frz_in);
    check("rw_cnt7", 32'(stall_count), 7);
    #1 rst = 1'b1;
    #1;
    check("rw_outs0", 32'(outs_now()),  0);
    check("rw_cnt0",  32'(stall_count), 0);
    @(posedge clk);
    @(negedge clk);
    apply('0);
    rst = 1'b0;
    model_reset();
    cycle("rw_post", idle);
    check("rw_no_residual", 32'(outs_now()), 32'(O_NONE));

    // Randomized traffic; the second half keeps memory busy long enough to time out.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      else cycle("rnd", rand_in((n < 1000) ? 50 : 92));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
